avg_line_raster: RTL and testbench
==================================

# avg_line_raster

Consumer end of the AVG line queue. Pops one line record at a time from `lineRegQueue` and walks it with an integer Bresenham stepper. Each on-screen point is emitted as a pixel write over a valid/ready interface to the framebuffer writer. Sits between the vector generator's line FIFO and the video framebuffer.

## Interface
- `SCREEN_W`, default 640: visible width in pixels.
- `SCREEN_H`, default 480: visible height in pixels.
- `X_ORIGIN`, default 320: screen column of vector X = 0.
- `Y_ORIGIN`, default 240: screen row of vector Y = 0.
- `PW`, default 10: pixel coordinate width.
- `clk_in` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `q_start_x`, `q_start_y`, `q_end_x`, `q_end_y` in 13: queue head coordinates, two's complement.
- `q_intensity` in 4: queue head intensity.
- `q_empty` in 1: queue holds no records.
- `q_read` out 1: one-cycle pop strobe.
- `pix_valid` out 1: pixel write request.
- `pix_ready` in 1: framebuffer accepts the pixel.
- `pix_x`, `pix_y` out PW: screen coordinates.
- `pix_intensity` out 4: pixel intensity.
- `busy` out 1: a line is in progress (any state other than IDLE).

## Operation
- States: IDLE, SETUP, DRAW.
- **IDLE**
  - If `!q_empty`: latch the head fields, assert `q_read` for exactly this cycle, go to SETUP.
  - `q_read` is never asserted while `q_empty` = 1 or outside IDLE.
- **SETUP** computes:
  - dx = |x1−x0| (14b)
  - dy = −|y1−y0| (14b signed)
  - sx = +1 if x0<x1, else −1
  - sy = +1 if y0<y1, else −1
  - err = dx+dy (15b signed)
  - (x,y) = (x0,y0)
  - If intensity == 0: discard the line and return to IDLE with no pixels.
  - Otherwise go to DRAW.
- **DRAW**, for the current point:
  - px = x + X_ORIGIN, py = Y_ORIGIN − y, both 15b signed.
  - On-screen means 0 ≤ px < SCREEN_W and 0 ≤ py < SCREEN_H.
  - On-screen point: drive `pix_valid`=1 with `pix_x`=px[PW-1:0], `pix_y`=py[PW-1:0], `pix_intensity`=latched intensity. Hold all of these stable until `pix_ready`. The point completes on `pix_valid && pix_ready`.
  - Off-screen point: `pix_valid`=0 and the point completes in one cycle.
- **On point completion**
  - If (x,y) == (x1,y1): go to IDLE.
  - Otherwise step, with e2 = 2·err (16b signed):
    - if e2 ≥ dy: err += dy, x += sx;
    - if e2 ≤ dx: err += dx, y += sy;
    - both adjustments use the pre-step err.
- Start == end produces exactly one point.
- Lines of any length up to 8192 steps per axis are supported; no internal width overflow.
- Reset mid-line abandons the line immediately. The already-popped record is lost; this is accepted.

## Timing
- Reset values:
  - `q_read`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_intensity`=0, `busy`=0
  - state IDLE, internal registers 0.
- Pop at cycle T (IDLE, `q_read`=1) → SETUP at T+1 → first `pix_valid` at T+2.
- Each point takes 1 cycle when `pix_ready`=1 (or when off-screen), plus one extra cycle per stalled `pix_ready`=0 cycle.
- Completion of the last point returns to IDLE on the next edge. The next pop can occur at the earliest in that IDLE cycle, giving a minimum 1-cycle gap between lines (no `pix_valid` in IDLE).
- `busy` is high from T+1 through the cycle in which the last point completes.
- A line of N points with no stalls occupies N+2 cycles including the pop cycle.
- Queue fields are sampled only in the pop cycle; changes to the queue head afterwards have no effect.

## Test plan
- **Horizontal line:** (0,0)→(3,0), intensity 5, `pix_ready`=1 → one `q_read` pulse; pixels (320,240),(321,240),(322,240),(323,240) on consecutive cycles, all intensity 5; `busy` low after 6 cycles.
- **Diagonal and steep lines:**
  - (0,0)→(−2,2) → (320,240),(319,239),(318,238).
  - (0,0)→(1,3) → (320,240),(320,239),(321,238),(321,237).
- **Backpressure:** same horizontal line with `pix_ready`=0 for 3 cycles while the 2nd pixel is presented → (321,240) held stable for 4 cycles, accepted once; no pixel lost or duplicated; total 9 cycles.
- **Clipping:** (315,0)→(325,0) → only x=635..639 emitted (5 pixels); line still takes 11 point-cycles + 2.
- **Queue edge cases:**
  - `q_empty`=1 held → `q_read` never asserts.
  - Intensity-0 record → popped, no `pix_valid`, back to IDLE after SETUP.
  - Start==end (7,−4) → single pixel (327,244).
  - Back-to-back records → pops are ≥1 idle cycle apart.
- **Reset mid-line:** assert `rst` during the 3rd pixel of a 10-pixel line → next cycle all outputs at reset values. After release with a non-empty queue, the next record is popped and drawn from its start.

Source files
------------

// File: rtl/avg_line_raster_if.sv
// Line-queue pop port and framebuffer pixel-write port of the AVG line rasteriser.
// master = rasteriser side, slave = queue + framebuffer side.
interface avg_line_raster_if #(
  parameter int PW = 10
);
  logic [12:0]   q_start_x;
  logic [12:0]   q_start_y;
  logic [12:0]   q_end_x;
  logic [12:0]   q_end_y;
  logic [3:0]    q_intensity;
  logic          q_empty;
  logic          q_read;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_x;
  logic [PW-1:0] pix_y;
  logic [3:0]    pix_intensity;

  modport master (
    input  q_start_x, q_start_y, q_end_x, q_end_y, q_intensity, q_empty, pix_ready,
    output q_read, pix_valid, pix_x, pix_y, pix_intensity
  );

  modport slave (
    output q_start_x, q_start_y, q_end_x, q_end_y, q_intensity, q_empty, pix_ready,
    input  q_read, pix_valid, pix_x, pix_y, pix_intensity
  );
endinterface

// File: rtl/avg_line_raster.sv
// Pops line records from the AVG line queue and walks each with an integer
// Bresenham stepper, emitting on-screen points as valid/ready pixel writes.
module avg_line_raster #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int X_ORIGIN = 320,
  parameter int Y_ORIGIN = 240,
  parameter int PW       = 10
) (
  input  logic              clk_in,
  input  logic              rst,
  avg_line_raster_if.master bus,
  output logic              busy
);
  localparam logic signed [14:0] SW = 15'(SCREEN_W);
  localparam logic signed [14:0] SH = 15'(SCREEN_H);
  localparam logic signed [14:0] XO = 15'(X_ORIGIN);
  localparam logic signed [14:0] YO = 15'(Y_ORIGIN);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  typedef struct packed {
    logic [12:0] x0;
    logic [12:0] y0;
    logic [12:0] x1;
    logic [12:0] y1;
    logic [3:0]  inten;
  } line_rec_t;

  state_t             state, state_nxt;
  line_rec_t          rec;
  logic [13:0]        dx;
  logic signed [13:0] dy;
  logic               sx_neg, sy_neg;
  logic signed [14:0] err;
  logic signed [12:0] x, y;

  logic               q_read_c, pix_valid_c;
  logic [PW-1:0]      pix_x_c, pix_y_c;
  logic [3:0]         pix_inten_c;

  // Setup arithmetic: 14b deltas cover the full 13b two's-complement span.
  logic signed [13:0] diff_x, diff_y, dy_init;
  logic [13:0]        abs_x, abs_y;

  assign diff_x  = $signed({rec.x1[12], rec.x1}) - $signed({rec.x0[12], rec.x0});
  assign diff_y  = $signed({rec.y1[12], rec.y1}) - $signed({rec.y0[12], rec.y0});
  assign abs_x   = diff_x[13] ? -diff_x : diff_x;
  assign abs_y   = diff_y[13] ? -diff_y : diff_y;
  assign dy_init = -$signed(abs_y);

  logic signed [14:0] px, py;
  logic               on_screen, at_end, pt_done;

  assign px        = $signed({{2{x[12]}}, x}) + XO;
  assign py        = YO - $signed({{2{y[12]}}, y});
  assign on_screen = (px >= 15'sd0) && (px < SW) && (py >= 15'sd0) && (py < SH);
  assign at_end    = (x == rec.x1) && (y == rec.y1);
  assign pt_done   = (state == DRAW) && (!on_screen || bus.pix_ready);

  // Both step decisions look at the pre-step error term.
  logic signed [15:0] e2, dx_w, dy_w;
  logic               step_x, step_y;
  logic signed [14:0] err_nxt;

  assign e2      = {err, 1'b0};
  assign dx_w    = {2'b00, dx};
  assign dy_w    = {{2{dy[13]}}, dy};
  assign step_x  = e2 >= dy_w;
  assign step_y  = e2 <= dx_w;
  assign err_nxt = err + (step_x ? $signed({dy[13], dy}) : 15'sd0)
                       + (step_y ? $signed({1'b0, dx})   : 15'sd0);

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    q_read_c    = 1'b0;
    pix_valid_c = 1'b0;
    pix_x_c     = '0;
    pix_y_c     = '0;
    pix_inten_c = '0;
    case (state)
      IDLE: begin
        if (!bus.q_empty && !rst) begin
          q_read_c  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = (rec.inten == 4'd0) ? IDLE : DRAW;
      DRAW: begin
        if (on_screen) begin
          pix_valid_c = 1'b1;
          pix_x_c     = px[PW-1:0];
          pix_y_c     = py[PW-1:0];
          pix_inten_c = rec.inten;
        end
        if (pt_done && at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rec    <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
      x      <= '0;
      y      <= '0;
    end else begin
      if (q_read_c)
        rec <= {bus.q_start_x, bus.q_start_y, bus.q_end_x, bus.q_end_y, bus.q_intensity};
      if (state == SETUP) begin
        dx     <= abs_x;
        dy     <= dy_init;
        sx_neg <= !($signed(rec.x0) < $signed(rec.x1));
        sy_neg <= !($signed(rec.y0) < $signed(rec.y1));
        err    <= $signed({1'b0, abs_x}) + $signed({dy_init[13], dy_init});
        x      <= rec.x0;
        y      <= rec.y0;
      end
      if (pt_done && !at_end) begin
        err <= err_nxt;
        if (step_x) x <= sx_neg ? x - 13'sd1 : x + 13'sd1;
        if (step_y) y <= sy_neg ? y - 13'sd1 : y + 13'sd1;
      end
    end
  end

  assign bus.q_read        = q_read_c;
  assign bus.pix_valid     = pix_valid_c;
  assign bus.pix_x         = pix_x_c;
  assign bus.pix_y         = pix_y_c;
  assign bus.pix_intensity = pix_inten_c;
  assign busy              = (state != IDLE);
endmodule

// File: tb/tb_avg_line_raster.sv
// Bench for avg_line_raster: queue feeder + integer line model feed a pixel
// scoreboard; a negedge monitor pops and compares every accepted pixel.
module tb_avg_line_raster;
  localparam int PW = 10;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic busy;

  avg_line_raster_if #(.PW(PW)) bus ();

  avg_line_raster #(
    .SCREEN_W(640), .SCREEN_H(480), .X_ORIGIN(320), .Y_ORIGIN(240), .PW(PW)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int x0; int y0; int x1; int y1; int inten;} rec_t;
  typedef struct {int x; int y; int inten;} pix_t;

  rec_t rec_q[$];
  pix_t exp_q[$];
  int   pop_log[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   acc_cnt = 0;
  int   cyc = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic drive_head();
    if (rec_q.size() == 0) begin
      bus.q_empty     = 1'b1;
      bus.q_start_x   = '0;
      bus.q_start_y   = '0;
      bus.q_end_x     = '0;
      bus.q_end_y     = '0;
      bus.q_intensity = '0;
    end else begin
      bus.q_empty     = 1'b0;
      bus.q_start_x   = 13'(rec_q[0].x0);
      bus.q_start_y   = 13'(rec_q[0].y0);
      bus.q_end_x     = 13'(rec_q[0].x1);
      bus.q_end_y     = 13'(rec_q[0].y1);
      bus.q_intensity = 4'(rec_q[0].inten);
    end
  endtask

  // Reference: walk the line in plain integers, keep points inside the screen.
  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input int inten);
    int dx, dy, sx, sy, err, e2, px, py, cx, cy;
    rec_t r;
    r = '{x0, y0, x1, y1, inten};
    rec_q.push_back(r);
    if (inten != 0) begin
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      sx = (x0 < x1) ? 1 : -1;
      sy = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      cx = x0;
      cy = y0;
      forever begin
        px = cx + 320;
        py = 240 - cy;
        if (px >= 0 && px < 640 && py >= 0 && py < 480) exp_q.push_back('{px, py, inten});
        if (cx == x1 && cy == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; cx += sx; end
        if (e2 <= dx) begin err += dx; cy += sy; end
      end
    end
    drive_head();
  endtask

  task automatic step(output bit active);
    bit pop_now;
    @(negedge clk_in);
    active  = bus.q_read || busy;
    pop_now = bus.q_read;
    @(posedge clk_in);
    #1;
    if (pop_now) begin
      pop_log.push_back(cyc);
      if (rec_q.size() > 0) rec_q.delete(0);
      drive_head();
    end
    cyc++;
  endtask

  // Runs from the current (pop) cycle until the DUT goes idle, stalling
  // pix_ready in cycles [st_start, st_start+st_len).
  task automatic run_until_idle(input string name, input int exp_cyc,
                                input int st_start, input int st_len);
    int c, pops0;
    bit act;
    c = 0;
    pops0 = pop_log.size();
    bus.pix_ready = !(c >= st_start && c < st_start + st_len);
    step(act);
    while (act && c < 20000) begin
      c++;
      bus.pix_ready = !(c >= st_start && c < st_start + st_len);
      step(act);
    end
    bus.pix_ready = 1'b1;
    check({name, " cycles"}, c, exp_cyc);
    check({name, " pops"}, pop_log.size() - pops0, 1);
    check({name, " left"}, exp_q.size(), 0);
  endtask

  task automatic run_line(input string name, input int x0, input int y0, input int x1,
                          input int y1, input int inten, input int exp_cyc,
                          input int st_start, input int st_len);
    push_line(x0, y0, x1, y1, inten);
    run_until_idle(name, exp_cyc, st_start, st_len);
  endtask

  task automatic check_rst_out(input string name);
    @(negedge clk_in);
    check({name, " q_read"}, int'(bus.q_read), 0);
    check({name, " pix_valid"}, int'(bus.pix_valid), 0);
    check({name, " pix_x"}, int'(bus.pix_x), 0);
    check({name, " pix_y"}, int'(bus.pix_y), 0);
    check({name, " pix_intensity"}, int'(bus.pix_intensity), 0);
    check({name, " busy"}, int'(busy), 0);
  endtask

  // Monitor: scoreboard pops, hold-while-stalled and pop-while-empty checks.
  initial begin
    bit   held;
    pix_t hp;
    pix_t e;
    held = 1'b0;
    hp = '{0, 0, 0};
    forever begin
      @(negedge clk_in);
      if (bus.q_read) begin
        vectors++;
        if (bus.q_empty) begin
          miscompares++;
          $display("FAIL q_read: got 1 with q_empty=1, want 0");
        end
      end
      if (held && !rst) begin
        vectors++;
        if (!bus.pix_valid || int'(bus.pix_x) != hp.x || int'(bus.pix_y) != hp.y ||
            int'(bus.pix_intensity) != hp.inten) begin
          miscompares++;
          $display("FAIL stall_hold: got v%0d (%0d,%0d,i%0d), want v1 (%0d,%0d,i%0d)",
                   bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_intensity, hp.x, hp.y, hp.inten);
        end
      end
      if (bus.pix_valid && bus.pix_ready) begin
        vectors++;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pixel: got (%0d,%0d,i%0d), want none", bus.pix_x, bus.pix_y,
                   bus.pix_intensity);
        end else begin
          e = exp_q.pop_front();
          if (int'(bus.pix_x) != e.x || int'(bus.pix_y) != e.y ||
              int'(bus.pix_intensity) != e.inten) begin
            miscompares++;
            $display("FAIL pixel: got (%0d,%0d,i%0d), want (%0d,%0d,i%0d)", bus.pix_x,
                     bus.pix_y, bus.pix_intensity, e.x, e.y, e.inten);
          end
        end
      end
      held = bus.pix_valid && !bus.pix_ready && !rst;
      hp = '{int'(bus.pix_x), int'(bus.pix_y), int'(bus.pix_intensity)};
    end
  end

  initial begin
    bit act;
    int n, base, guard, p0;
    bus.pix_ready = 1'b1;
    drive_head();
    repeat (3) @(posedge clk_in);
    check_rst_out("reset");
    @(posedge clk_in);
    #1;
    rst = 1'b0;

    // Empty queue: no pops, no activity.
    n = 0;
    repeat (8) begin
      step(act);
      if (act) n++;
    end
    check("empty_queue active", n, 0);

    run_line("horizontal", 0, 0, 3, 0, 5, 6, 0, 0);
    run_line("diagonal", 0, 0, -2, 2, 9, 5, 0, 0);
    run_line("steep", 0, 0, 1, 3, 3, 6, 0, 0);
    run_line("backpressure", 0, 0, 3, 0, 5, 9, 3, 3);
    run_line("clip", 315, 0, 325, 0, 7, 13, 0, 0);
    run_line("inten0", -5, 5, 20, -8, 0, 2, 0, 0);
    run_line("single", 7, -4, 7, -4, 15, 3, 0, 0);
    run_line("long_diag", -4096, -4096, 4095, 4095, 6, 8194, 0, 0);
    run_line("long_shallow", -4096, 3, 4095, -2, 11, 8194, 0, 0);

    // Back-to-back records: pops spaced by the previous line's occupancy.
    p0 = pop_log.size();
    push_line(0, 0, 3, 0, 2);
    push_line(1, 1, 9, 9, 0);
    push_line(7, -4, 7, -4, 4);
    guard = 0;
    do begin
      step(act);
      guard++;
    end while ((act || rec_q.size() > 0) && guard < 200);
    check("b2b pops", pop_log.size() - p0, 3);
    if (pop_log.size() - p0 == 3) begin
      check("b2b gap1", pop_log[p0 + 1] - pop_log[p0], 6);
      check("b2b gap2", pop_log[p0 + 2] - pop_log[p0 + 1], 2);
    end
    check("b2b left", exp_q.size(), 0);

    // Reset while the 3rd pixel of a 10-pixel line is presented.
    push_line(0, 0, 9, 0, 8);
    base = acc_cnt;
    guard = 0;
    while (acc_cnt < base + 2 && guard < 50) begin
      step(act);
      guard++;
    end
    check("reset_mid reached", acc_cnt - base, 2);
    rst = 1'b1;
    step(act);
    exp_q.delete();
    push_line(2, 1, 4, 1, 12);
    check_rst_out("reset_mid");
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    run_until_idle("after_reset", 5, 0, 0);

    // Randomized lines with random backpressure.
    for (int i = 0; i < 20; i++)
      push_line($urandom_range(0, 680) - 340, $urandom_range(0, 520) - 260,
                $urandom_range(0, 680) - 340, $urandom_range(0, 520) - 260,
                $urandom_range(0, 15));
    guard = 0;
    do begin
      bus.pix_ready = ($urandom_range(0, 3) != 0);
      step(act);
      guard++;
    end while ((act || rec_q.size() > 0) && guard < 60000);
    bus.pix_ready = 1'b1;
    check("random timeout", int'(guard >= 60000), 0);
    check("random left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
